// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared state encoding, uart constants and counter sizing helper
package uart_tx_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, GAP = 2'd2} arb_state_e;
  localparam int BAUD = 115200;
  localparam int CLK_FRE = 50;
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: one-hot pick of the first set request searching upward from ptr with wrap
module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          any
);
  // scan offsets from farthest to nearest so the nearest set bit to ptr wins
  always_comb begin
    pick = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) pick = N'(1) << ((int'(ptr) + k) % N);
  end
  assign any = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-atomic round-robin sharing of one uart_tx byte port
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int GAP_CYCLES   = 0,
  parameter int IDLE_TIMEOUT = 5000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_data_valid,
  input  logic                 tx_data_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout_err
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int IW = cnt_w(IDLE_TIMEOUT);
  localparam int GW = cnt_w(GAP_CYCLES);
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  arb_state_e state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, pick;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d, g_idx, nxt_ptr;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic any, done;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .pick(pick),
    .any (any)
  );

  // index of the current owner; only meaningful while grant is one-hot
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) if (grant_q[i]) g_idx = PW'(i);
  end

  assign nxt_ptr = (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + PW'(1);
  assign grant   = grant_q;
  assign busy    = state_q != IDLE;

  // combinational pass-through from the owner to uart_tx and back
  always_comb begin
    tx_data_valid = (state_q == XFER) && req_valid[g_idx];
    tx_data = tx_data_valid ? req_data[{g_idx, 3'b000} +: 8] : 8'h00;
    req_ready = '0;
    req_ready[g_idx] = (state_q == XFER) && tx_data_ready;
  end

  // arbitration, message completion, eviction and gap sequencing
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_ptr_d = rr_ptr_q;
    idle_cnt_d = idle_cnt_q;
    gap_cnt_d = gap_cnt_q;
    timeout_err = 1'b0;
    done = 1'b0;
    case (state_q)
      IDLE: if (any) begin
        grant_d = pick;
        idle_cnt_d = '0;
        state_d = XFER;
      end
      XFER: begin
        if (tx_data_valid && tx_data_ready && req_last[g_idx]) done = 1'b1;
        else if (req_valid[g_idx]) idle_cnt_d = '0;
        else if (idle_cnt_q == IW'(IDLE_TIMEOUT - 1)) begin
          done = 1'b1;
          timeout_err = 1'b1;
        end
        else idle_cnt_d = idle_cnt_q + IW'(1);
        if (done) begin
          grant_d = '0;
          rr_ptr_d = nxt_ptr;
          idle_cnt_d = '0;
          gap_cnt_d = '0;
          state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (gap_cnt_q == GW'(GAP_LAST)) begin
          gap_cnt_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_ptr_q <= '0;
      idle_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      idle_cnt_q <= idle_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for two arbiter configurations (2 req no gap, 4 req gap 3)
module tb_uart_tx_arbiter;
  typedef struct {int r; logic [7:0] b;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int u0, u1;
  logic [7:0] src_data [2][4];
  logic src_valid [2][4];
  logic src_last [2][4];
  logic [15:0] d0_req_data;
  logic [1:0] d0_req_valid, d0_req_last, d0_req_ready, d0_grant;
  logic [7:0] d0_tx_data;
  logic d0_tx_valid, d0_tx_ready, d0_busy, d0_to;
  logic [31:0] d1_req_data;
  logic [3:0] d1_req_valid, d1_req_last, d1_req_ready, d1_grant;
  logic [7:0] d1_tx_data;
  logic d1_tx_valid, d1_tx_ready, d1_busy, d1_to;

  always #5 clk = ~clk;

  always_comb begin
    d0_req_data = '0;
    d0_req_valid = '0;
    d0_req_last = '0;
    d1_req_data = '0;
    d1_req_valid = '0;
    d1_req_last = '0;
    for (int i = 0; i < 2; i++) begin
      d0_req_data[i*8 +: 8] = src_data[0][i];
      d0_req_valid[i] = src_valid[0][i];
      d0_req_last[i] = src_last[0][i];
    end
    for (int i = 0; i < 4; i++) begin
      d1_req_data[i*8 +: 8] = src_data[1][i];
      d1_req_valid[i] = src_valid[1][i];
      d1_req_last[i] = src_last[1][i];
    end
  end

  uart_tx_arbiter #(.NUM_REQ(2), .GAP_CYCLES(0), .IDLE_TIMEOUT(20)) dut0 (
    .clk(clk), .rst(rst), .req_data(d0_req_data), .req_valid(d0_req_valid),
    .req_last(d0_req_last), .req_ready(d0_req_ready), .tx_data(d0_tx_data),
    .tx_data_valid(d0_tx_valid), .tx_data_ready(d0_tx_ready), .grant(d0_grant),
    .busy(d0_busy), .timeout_err(d0_to)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(3), .IDLE_TIMEOUT(20)) dut1 (
    .clk(clk), .rst(rst), .req_data(d1_req_data), .req_valid(d1_req_valid),
    .req_last(d1_req_last), .req_ready(d1_req_ready), .tx_data(d1_tx_data),
    .tx_data_valid(d1_tx_valid), .tx_data_ready(d1_tx_ready), .grant(d1_grant),
    .busy(d1_busy), .timeout_err(d1_to)
  );

  // uart_tx models: ready drops for 10 clocks after each accepted byte
  always_ff @(posedge clk) begin
    if (rst) u0 <= 0;
    else if (d0_tx_valid && d0_tx_ready) u0 <= 10;
    else if (u0 > 0) u0 <= u0 - 1;
    if (rst) u1 <= 0;
    else if (d1_tx_valid && d1_tx_ready) u1 <= 10;
    else if (u1 > 0) u1 <= u1 - 1;
  end
  assign d0_tx_ready = (u0 == 0);
  assign d1_tx_ready = (u1 == 0);

  // scoreboard monitors: every byte handed to uart_tx must match the next expected byte and owner
  always @(negedge clk) begin
    #2;
    if (!rst && d0_tx_valid && d0_tx_ready) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL sb0 unexpected byte data=%h grant=%b", d0_tx_data, d0_grant);
      end else begin
        e0 = q0.pop_front();
        if (d0_tx_data !== e0.b || d0_grant !== 2'(1 << e0.r)) begin
          failures++;
          $display("FAIL sb0 byte got data=%h grant=%b want data=%h grant=%b",
                   d0_tx_data, d0_grant, e0.b, 2'(1 << e0.r));
        end
      end
    end
    if (!rst && d1_tx_valid && d1_tx_ready) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL sb1 unexpected byte data=%h grant=%b", d1_tx_data, d1_grant);
      end else begin
        e1 = q1.pop_front();
        if (d1_tx_data !== e1.b || d1_grant !== 4'(1 << e1.r)) begin
          failures++;
          $display("FAIL sb1 byte got data=%h grant=%b want data=%h grant=%b",
                   d1_tx_data, d1_grant, e1.b, 4'(1 << e1.r));
        end
      end
    end
  end

  function automatic logic rdy(input int d, input int r);
    logic [3:0] t;
    t = (d == 0) ? {2'b00, d0_req_ready} : d1_req_ready;
    return t[r];
  endfunction

  task automatic push(input int d, input int r, input string s);
    for (int k = 0; k < s.len(); k++)
      if (s[k] != 8'h7c) begin
        if (d == 0) q0.push_back('{r, s[k]});
        else q1.push_back('{r, s[k]});
      end
  endtask

  // requester model: '|' after a byte marks it as the last byte of its message
  task automatic send(input int d, input int r, input string s);
    int n;
    for (int k = 0; k < s.len(); k++) begin
      if (s[k] == 8'h7c) continue;
      @(negedge clk);
      src_data[d][r] = s[k];
      src_valid[d][r] = 1'b1;
      src_last[d][r] = (k + 1 < s.len()) && (s[k+1] == 8'h7c);
      #1;
      n = 0;
      while (!rdy(d, r) && n < 500) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (n >= 500) begin
        checks++;
        failures++;
        $display("FAIL send_wait dut%0d req%0d ready=0 want=1 after 500 clk", d, r);
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    src_valid[d][r] = 1'b0;
    src_last[d][r] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 4; r++) begin
        src_valid[d][r] = 1'b0;
        src_last[d][r] = 1'b0;
        src_data[d][r] = 8'h00;
      end
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_valid[0][0] = 1'b1;
    src_valid[1][2] = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({d0_grant, d0_busy, d0_tx_valid, d0_tx_data, d0_req_ready, d0_to} !== 15'd0) begin
      failures++;
      $display("FAIL reset0 got %h want 0", {d0_grant, d0_busy, d0_tx_valid, d0_tx_data, d0_req_ready, d0_to});
    end
    checks++;
    if ({d1_grant, d1_busy, d1_tx_valid, d1_tx_data, d1_req_ready, d1_to} !== 19'd0) begin
      failures++;
      $display("FAIL reset1 got %h want 0", {d1_grant, d1_busy, d1_tx_valid, d1_tx_data, d1_req_ready, d1_to});
    end
    do_reset();
  endtask

  task automatic test_two_messages();
    do_reset();
    push(0, 0, "AB\n");
    push(0, 1, "XY\n");
    fork
      send(0, 0, "AB\n|");
      send(0, 1, "XY\n|");
    join
    wait_drain();
    checks++;
    if (q0.size() != 0) begin
      failures++;
      $display("FAIL two_msg_left got %0d want 0", q0.size());
    end
  endtask

  task automatic test_fairness();
    string s = "xyz";
    do_reset();
    for (int m = 0; m < 3; m++) begin
      q0.push_back('{0, 8'h70});
      q0.push_back('{0, 8'h30 + 8'(m)});
      q0.push_back('{1, s[m]});
    end
    fork
      send(0, 0, "p0|p1|p2|");
      send(0, 1, "x|y|z|");
    join
    wait_drain();
    checks++;
    if (q0.size() != 0) begin
      failures++;
      $display("FAIL fair_left got %0d want 0", q0.size());
    end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    int first = 0;
    logic [1:0] g21 = 2'b11;
    logic [1:0] g22 = 2'b11;
    do_reset();
    push(0, 0, "Q");
    push(0, 1, "Z");
    fork
      send(0, 1, "Z|");
    join_none
    send(0, 0, "Q");
    for (int i = 1; i <= 25; i++) begin
      #1;
      if (d0_to) begin
        pulses++;
        if (first == 0) first = i;
      end
      if (i == 21) g21 = d0_grant;
      if (i == 22) g22 = d0_grant;
      @(negedge clk);
    end
    wait fork;
    wait_drain();
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL timeout_pulses got %0d want 1", pulses);
    end
    checks++;
    if (first != 20) begin
      failures++;
      $display("FAIL timeout_delay got %0d want 20", first);
    end
    checks++;
    if (g21 !== 2'b00) begin
      failures++;
      $display("FAIL timeout_clear got %b want 00", g21);
    end
    checks++;
    if (g22 !== 2'b10) begin
      failures++;
      $display("FAIL timeout_next got %b want 10", g22);
    end
  endtask

  task automatic test_gap();
    int n = 0;
    int low = 0;
    logic gbusy = 1'b0;
    do_reset();
    push(1, 0, "ab");
    fork
      send(1, 0, "a|b|");
      begin
        @(negedge clk);
        #1;
        while (!d1_tx_valid && n < 100) begin @(negedge clk); #1; n++; end
        while (d1_tx_valid && n < 200) begin @(negedge clk); #1; n++; end
        gbusy = d1_busy;
        while (!d1_tx_valid && low < 50) begin @(negedge clk); #1; low++; end
      end
    join
    wait_drain();
    checks++;
    if (low != 4) begin
      failures++;
      $display("FAIL gap_low got %0d want 4", low);
    end
    checks++;
    if (gbusy !== 1'b1) begin
      failures++;
      $display("FAIL gap_busy got %b want 1", gbusy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(0, 0, "K");
    push(0, 1, "P");
    push(0, 0, "S");
    push(0, 1, "T");
    send(0, 0, "K|");
    send(0, 1, "P");
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({d0_grant, d0_busy, d0_tx_valid} !== 4'b0) begin
      failures++;
      $display("FAIL rst_mid got grant=%b busy=%b valid=%b want 00 0 0", d0_grant, d0_busy, d0_tx_valid);
    end
    rst = 1'b0;
    fork
      send(0, 0, "S|");
      send(0, 1, "T|");
    join
    wait_drain();
    checks++;
    if (q0.size() != 0) begin
      failures++;
      $display("FAIL rst_mid_left got %0d want 0", q0.size());
    end
  endtask

  task automatic test_rr4();
    int n = 0;
    do_reset();
    push(1, 1, "A");
    push(1, 3, "C");
    push(1, 1, "D");
    send(1, 1, "A|");
    #1;
    while (d1_busy && n < 100) begin @(negedge clk); #1; n++; end
    fork
      send(1, 3, "C|");
      send(1, 1, "D|");
    join
    wait_drain();
    checks++;
    if (q1.size() != 0) begin
      failures++;
      $display("FAIL rr4_left got %0d want 0", q1.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 4; r++) begin
        src_valid[d][r] = 1'b0;
        src_last[d][r] = 1'b0;
        src_data[d][r] = 8'h00;
      end
    test_reset();
    test_two_messages();
    test_fairness();
    test_timeout();
    test_gap();
    test_reset_mid();
    test_rr4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
